rotary_quad_decoder: RTL and testbench
======================================

Name: rotary_quad_decoder

Overview:
Front-end stage between the board's rotary-encoder pins (ROT_A, ROT_B, btn) and the display path that drives anode/cathode.
- Synchronises and debounces all three raw inputs.
- Decodes the Gray-coded A/B quadrature sequence into whole-detent up/down steps.
- Keeps a wrapping position counter, which the 7-segment driver consumes directly.
- A button press clears the counter.

Parameters:
DEBOUNCE_CYCLES, 1000, consecutive identical synchronised samples required before a filtered input updates (10 us at 100 MHz); range 1..65535
COUNT_W, 16, width of the position counter

Ports:
clk  input  1  system clock, 100 MHz, all logic on rising edge
reset  input  1  synchronous, active-high reset
ROT_A  input  1  raw encoder channel A, asynchronous
ROT_B  input  1  raw encoder channel B, asynchronous
btn  input  1  raw encoder push-button, asynchronous, active-high
count  output  COUNT_W  position counter, unsigned, wraps
step_up  output  1  one-cycle pulse per completed CW detent
step_down  output  1  one-cycle pulse per completed CCW detent
btn_pulse  output  1  one-cycle pulse on debounced btn rising edge
quad_err  output  1  one-cycle pulse on illegal A/B transition (both bits change)

Behaviour:
- Reset (reset=1 at a clk edge):
  - Synchroniser flops, debounce counters, filtered A/B/btn and the phase accumulator all go to 0.
  - count=0; step_up=step_down=btn_pulse=quad_err=0.
  - Reset mid-rotation discards the partial detent.
- Synchroniser: two flops per input; the synchronised value lags raw by 2 cycles.
- Debounce (per input):
  - Counter restarts whenever the synchronised sample differs from the previous sample.
  - When the sample has been stable for DEBOUNCE_CYCLES consecutive cycles and differs from the filtered value, the filtered value takes the sample.
  - Glitches shorter than DEBOUNCE_CYCLES never reach the filtered value.
- Quadrature FSM on filtered AB (A is the MSB):
  - CW order is 00->01->11->10->00; CCW order is 00->10->11->01->00.
  - Each legal CW transition adds +1 to the phase accumulator (signed, 4 bits, range -4..+4). Each legal CCW transition adds -1.
  - On entry to AB=00:
    - acc reaching +4 -> step_up.
    - acc reaching -4 -> step_down.
    - In every case acc clears to 0.
  - Partial turns and direction reversals therefore produce no step.
  - Illegal transitions (00<->11, 01<->10):
    - quad_err pulses.
    - acc is unchanged, except that entry to 00 still clears it.
    - No step is generated.
  - Simultaneous A and B filtered updates in the same cycle are treated as one transition.
- Latency: step_up/step_down/quad_err assert exactly 1 cycle after the filtered AB update. count reflects the step in the same cycle the pulse is high.
- Counter:
  - step_up -> count+1, wraps 2^COUNT_W-1 -> 0.
  - step_down -> count-1, wraps 0 -> 2^COUNT_W-1.
- Button: btn_pulse asserts 1 cycle after filtered btn rises. count reads 0 in the btn_pulse cycle.
- Priority: reset > btn clear > step. A step coinciding with btn_pulse is dropped and count=0.

Decomposition:
- Package rotary_pkg holds:
  - Phase constants PH_00, PH_01, PH_11, PH_10.
  - DETENT_TRANSITIONS=4.
  - ACC_W=4.
  - Default DEBOUNCE_CYCLES.
- Sub-module debounce_filter(DEBOUNCE_CYCLES):
  - Ports clk, reset, din_raw, dout. Contains both synchroniser flops and the stable counter.
  - Instantiated three times: ROT_A, ROT_B, btn.
- Quadrature FSM and counter stay in rotary_quad_decoder.

Test Plan:
All scenarios run with DEBOUNCE_CYCLES=4 and each input level held for 10 cycles unless stated.
1. Reset: hold reset=1 for 3 cycles with inputs at 11 -> count=0, all pulses 0. After release, filtered 00->11 -> exactly one quad_err, count stays 0.
2. One CW detent (AB 00->01->11->10->00) -> exactly one step_up pulse, 1 cycle after filtered AB=00; count 0->1; quad_err never asserted.
3. Three CCW detents from count=0 (00->10->11->01->00 x3) -> three step_down pulses; count=0xFFFF, then 0xFFFE, then 0xFFFD.
4. Partial rotation with reversal (00->01->11->01->00) -> no step pulses, count unchanged. Then 0xFFFF plus one CW detent -> count=0x0000.
5. Filter and illegal transition:
   - A glitch 0->1->0 lasting 3 cycles -> no change to filtered A, no pulses.
   - Raw AB 00->11 held 10 cycles -> one quad_err, no step.
6. Button:
   - With count=5, btn high for 10 cycles -> one btn_pulse, count=0.
   - A CW detent completing in the btn_pulse cycle -> count=0, and step_up is still pulsed.

Source files
------------

// File: rtl/rotary_pkg.sv
// Shared constants for the rotary encoder front end: quadrature phases,
// detent size, phase accumulator width and the default debounce length.
package rotary_pkg;

  // Filtered {A,B} phase, A is the MSB.
  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_11 = 2'b11,
    PH_10 = 2'b10
  } phase_e;

  localparam int unsigned DETENT_TRANSITIONS      = 4;
  localparam int unsigned ACC_W                   = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000;

  // Next phase in the clockwise sequence 00->01->11->10->00.
  function automatic logic [1:0] cw_next(input logic [1:0] ph);
    logic [1:0] nxt;
    unique case (ph)
      2'b00:   nxt = 2'b01;
      2'b01:   nxt = 2'b11;
      2'b11:   nxt = 2'b10;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a stability counter. The filtered output
// only follows the synchronised input once it has held the same value for
// DEBOUNCE_CYCLES consecutive samples.
module debounce_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic din_raw,
  output logic dout
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic             r_dout;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_update;

  // Length of the current run of identical samples, including this one;
  // saturates at LIMIT so it cannot wrap.
  always_comb begin
    w_cnt_next = r_cnt;
    if (r_sync2 != r_prev) begin
      w_cnt_next = CNT_W'(1);
    end else if (r_cnt < LIMIT) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
    w_update = (w_cnt_next >= LIMIT) && (r_sync2 != r_dout);
  end

  // Synchroniser, run-length counter and filtered output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_cnt   <= '0;
      r_dout  <= 1'b0;
    end else begin
      r_sync1 <= din_raw;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_cnt   <= w_cnt_next;
      if (w_update) begin
        r_dout <= r_sync2;
      end
    end
  end

  assign dout = r_dout;

endmodule

// File: rtl/rotary_quad_decoder.sv
// Rotary encoder front end: debounces A/B/button, decodes whole quadrature
// detents into step pulses and keeps a wrapping position counter that the
// button clears.
module rotary_quad_decoder
  import rotary_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned COUNT_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ROT_A,
  input  logic               ROT_B,
  input  logic               btn,
  output logic [COUNT_W-1:0] count,
  output logic               step_up,
  output logic               step_down,
  output logic               btn_pulse,
  output logic               quad_err
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(DETENT_TRANSITIONS);
  localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);

  logic w_a;
  logic w_b;
  logic w_btn;

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk     (clk),
    .reset   (reset),
    .din_raw (ROT_A),
    .dout    (w_a)
  );

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk     (clk),
    .reset   (reset),
    .din_raw (ROT_B),
    .dout    (w_b)
  );

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_btn (
    .clk     (clk),
    .reset   (reset),
    .din_raw (btn),
    .dout    (w_btn)
  );

  phase_e                   r_ab_prev;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_btn_prev;
  logic [COUNT_W-1:0]       r_count;
  logic                     r_step_up;
  logic                     r_step_down;
  logic                     r_btn_pulse;
  logic                     r_quad_err;

  logic [1:0]               w_ab;
  logic                     w_changed;
  logic                     w_is_cw;
  logic                     w_is_ccw;
  logic                     w_illegal;
  logic                     w_enter00;
  logic signed [ACC_W-1:0]  w_acc_sum;
  logic                     w_step_up;
  logic                     w_step_down;
  logic                     w_btn_rise;

  // Classify the filtered AB change; A and B moving in the same cycle count
  // as a single (illegal) transition.
  always_comb begin
    w_ab      = {w_a, w_b};
    w_changed = (w_ab != r_ab_prev);
    w_is_cw   = w_changed && (cw_next(r_ab_prev) == w_ab);
    w_is_ccw  = w_changed && (cw_next(w_ab) == r_ab_prev);
    w_illegal = w_changed && !w_is_cw && !w_is_ccw;
    w_enter00 = w_changed && (w_ab == PH_00);

    // Clamped so odd legal/illegal mixes cannot wrap the accumulator.
    w_acc_sum = r_acc;
    if (w_is_cw && (r_acc != ACC_MAX)) begin
      w_acc_sum = r_acc + ACC_ONE;
    end else if (w_is_ccw && (r_acc != ACC_MIN)) begin
      w_acc_sum = r_acc - ACC_ONE;
    end

    w_step_up   = w_enter00 && !w_illegal && (w_acc_sum == ACC_MAX);
    w_step_down = w_enter00 && !w_illegal && (w_acc_sum == ACC_MIN);
    w_btn_rise  = w_btn && !r_btn_prev;
  end

  // Quadrature FSM, registered pulses and position counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ab_prev   <= PH_00;
      r_acc       <= '0;
      r_btn_prev  <= 1'b0;
      r_count     <= '0;
      r_step_up   <= 1'b0;
      r_step_down <= 1'b0;
      r_btn_pulse <= 1'b0;
      r_quad_err  <= 1'b0;
    end else begin
      r_ab_prev   <= phase_e'(w_ab);
      r_acc       <= w_enter00 ? '0 : w_acc_sum;
      r_btn_prev  <= w_btn;
      r_step_up   <= w_step_up;
      r_step_down <= w_step_down;
      r_btn_pulse <= w_btn_rise;
      r_quad_err  <= w_illegal;
      // Button clear wins over a coincident step.
      if (w_btn_rise) begin
        r_count <= '0;
      end else if (w_step_up) begin
        r_count <= r_count + COUNT_W'(1);
      end else if (w_step_down) begin
        r_count <= r_count - COUNT_W'(1);
      end
    end
  end

  assign count     = r_count;
  assign step_up   = r_step_up;
  assign step_down = r_step_down;
  assign btn_pulse = r_btn_pulse;
  assign quad_err  = r_quad_err;

endmodule

// File: tb/tb_rotary_quad_decoder.sv
// Directed bench for rotary_quad_decoder with a short debounce window.
module tb_rotary_quad_decoder;

  logic        clk;
  logic        reset;
  logic        ROT_A;
  logic        ROT_B;
  logic        btn;
  logic [15:0] count;
  logic        step_up;
  logic        step_down;
  logic        btn_pulse;
  logic        quad_err;

  int n_vec = 0;
  int n_err = 0;
  int n_up  = 0;
  int n_dn  = 0;
  int n_btn = 0;
  int n_qe  = 0;

  rotary_quad_decoder #(
    .DEBOUNCE_CYCLES (4),
    .COUNT_W         (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ROT_A     (ROT_A),
    .ROT_B     (ROT_B),
    .btn       (btn),
    .count     (count),
    .step_up   (step_up),
    .step_down (step_down),
    .btn_pulse (btn_pulse),
    .quad_err  (quad_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (step_up)   n_up++;
    if (step_down) n_dn++;
    if (btn_pulse) n_btn++;
    if (quad_err)  n_qe++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    n_up  = 0;
    n_dn  = 0;
    n_btn = 0;
    n_qe  = 0;
  endtask

  task automatic drive_ab(input logic a, input logic b);
    @(negedge clk);
    ROT_A = a;
    ROT_B = b;
    repeat (10) @(posedge clk);
  endtask

  task automatic cw_detent();
    drive_ab(1'b0, 1'b1);
    drive_ab(1'b1, 1'b1);
    drive_ab(1'b1, 1'b0);
    drive_ab(1'b0, 1'b0);
  endtask

  task automatic ccw_detent();
    drive_ab(1'b1, 1'b0);
    drive_ab(1'b1, 1'b1);
    drive_ab(1'b0, 1'b1);
    drive_ab(1'b0, 1'b0);
  endtask

  initial begin
    // 1. Reset with inputs at 11, then filtered 00->11 is illegal.
    reset = 1'b1;
    ROT_A = 1'b1;
    ROT_B = 1'b1;
    btn   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'h0);
    check("rst_up", 32'(step_up), 32'h0);
    check("rst_down", 32'(step_down), 32'h0);
    check("rst_btn", 32'(btn_pulse), 32'h0);
    check("rst_qerr", 32'(quad_err), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    clr_mon();
    repeat (12) @(posedge clk);
    #1;
    check("rst_11_qerr", 32'(n_qe), 32'd1);
    check("rst_11_count", 32'(count), 32'h0);
    check("rst_11_steps", 32'(n_up + n_dn), 32'd0);
    drive_ab(1'b0, 1'b0);

    // 2. One CW detent with exact pulse latency on the final 10->00 edge.
    clr_mon();
    drive_ab(1'b0, 1'b1);
    drive_ab(1'b1, 1'b1);
    drive_ab(1'b1, 1'b0);
    @(negedge clk);
    ROT_A = 1'b0;
    ROT_B = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("cw_early", 32'(step_up), 32'h0);
    @(posedge clk);
    #1;
    check("cw_pulse", 32'(step_up), 32'h1);
    check("cw_count_same_cycle", 32'(count), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    check("cw_n_up", 32'(n_up), 32'd1);
    check("cw_n_qerr", 32'(n_qe), 32'd0);
    check("cw_n_down", 32'(n_dn), 32'd0);

    // 3. Three CCW detents from 0 -> wrap below zero.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clr_mon();
    ccw_detent();
    #1;
    check("ccw1_count", 32'(count), 32'hFFFF);
    ccw_detent();
    #1;
    check("ccw2_count", 32'(count), 32'hFFFE);
    ccw_detent();
    #1;
    check("ccw3_count", 32'(count), 32'hFFFD);
    check("ccw_n_down", 32'(n_dn), 32'd3);
    check("ccw_n_up", 32'(n_up), 32'd0);

    // 4. Reversal mid-detent gives no step; then wrap 0xFFFF -> 0.
    clr_mon();
    drive_ab(1'b0, 1'b1);
    drive_ab(1'b1, 1'b1);
    drive_ab(1'b0, 1'b1);
    drive_ab(1'b0, 1'b0);
    #1;
    check("rev_steps", 32'(n_up + n_dn), 32'd0);
    check("rev_count", 32'(count), 32'hFFFD);
    cw_detent();
    cw_detent();
    #1;
    check("wrap_pre", 32'(count), 32'hFFFF);
    cw_detent();
    #1;
    check("wrap_count", 32'(count), 32'h0000);
    check("wrap_n_up", 32'(n_up), 32'd3);

    // 5. Short glitch is filtered; raw 00->11 yields one quad_err.
    clr_mon();
    @(negedge clk);
    ROT_A = 1'b1;
    repeat (3) @(negedge clk);
    ROT_A = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("glitch_pulses", 32'(n_up + n_dn + n_qe + n_btn), 32'd0);
    drive_ab(1'b1, 1'b1);
    #1;
    check("illegal_qerr", 32'(n_qe), 32'd1);
    check("illegal_steps", 32'(n_up + n_dn), 32'd0);
    check("illegal_count", 32'(count), 32'h0000);
    drive_ab(1'b0, 1'b0);

    // 6. Button clears; a detent coinciding with btn_pulse still pulses
    //    step_up but leaves count at 0.
    for (int i = 0; i < 5; i++) cw_detent();
    #1;
    check("btn_pre_count", 32'(count), 32'd5);
    clr_mon();
    @(negedge clk);
    btn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("btn_n_pulse", 32'(n_btn), 32'd1);
    check("btn_count", 32'(count), 32'h0);
    @(negedge clk);
    btn = 1'b0;
    repeat (10) @(posedge clk);
    cw_detent();
    #1;
    check("btn_post_count", 32'(count), 32'h1);
    clr_mon();
    drive_ab(1'b0, 1'b1);
    drive_ab(1'b1, 1'b1);
    drive_ab(1'b1, 1'b0);
    @(negedge clk);
    ROT_A = 1'b0;
    ROT_B = 1'b0;
    btn   = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("coinc_up", 32'(step_up), 32'h1);
    check("coinc_btn", 32'(btn_pulse), 32'h1);
    check("coinc_count", 32'(count), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("coinc_n_up", 32'(n_up), 32'd1);
    check("coinc_count_after", 32'(count), 32'h0);
    @(negedge clk);
    btn = 1'b0;
    repeat (10) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
